// File: rtl/decode_execute_register.sv
// ID/EX pipeline register: latches the decoded instruction for Execute, with stall hold,
// flush-to-bubble and forwarding of the same-cycle write-back result into the operands.
module decode_execute_register #(
    parameter int                 XLEN     = 32,
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              idValid,
    input  logic [XLEN-1:0]   idPc,
    input  logic [XLEN-1:0]   idReadData1,
    input  logic [XLEN-1:0]   idReadData2,
    input  logic [4:0]        idRs1,
    input  logic [4:0]        idRs2,
    input  logic [4:0]        idRd,
    input  logic [XLEN-1:0]   idImmediate,
    input  logic [CTRL_W-1:0] idControl,
    input  logic              wbRegisterWrite,
    input  logic [4:0]        wbRd,
    input  logic [XLEN-1:0]   wbWriteData,
    input  logic              stall,
    input  logic              flush,
    output logic              exValid,
    output logic [XLEN-1:0]   exPc,
    output logic [XLEN-1:0]   exReadData1,
    output logic [XLEN-1:0]   exReadData2,
    output logic [4:0]        exRs1,
    output logic [4:0]        exRs2,
    output logic [4:0]        exRd,
    output logic [XLEN-1:0]   exImmediate,
    output logic [CTRL_W-1:0] exControl
);

    logic              vld_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [XLEN-1:0]   rdata1_p1;
    logic [XLEN-1:0]   rdata2_p1;
    logic [4:0]        rs1_p1;
    logic [4:0]        rs2_p1;
    logic [4:0]        rd_p1;
    logic [XLEN-1:0]   imm_p1;
    logic [CTRL_W-1:0] ctrl_p1;

    // Register file writes at the edge, so a matching WB write replaces a stale operand; x0 never forwards.
    function automatic logic [XLEN-1:0] forward(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] cur,
        input logic            we,
        input logic [4:0]      wrd,
        input logic [XLEN-1:0] wdata
    );
        return (we && (wrd == rs) && (rs != 5'd0)) ? wdata : cur;
    endfunction

    // ID -> EX stage boundary
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            vld_p1    <= 1'b0;
            pc_p1     <= '0;
            rdata1_p1 <= '0;
            rdata2_p1 <= '0;
            rs1_p1    <= '0;
            rs2_p1    <= '0;
            rd_p1     <= '0;
            imm_p1    <= '0;
            ctrl_p1   <= NOP_CTRL;
        end else if (stall) begin
            rdata1_p1 <= forward(rs1_p1, rdata1_p1, wbRegisterWrite, wbRd, wbWriteData);
            rdata2_p1 <= forward(rs2_p1, rdata2_p1, wbRegisterWrite, wbRd, wbWriteData);
        end else begin
            vld_p1    <= idValid;
            pc_p1     <= idPc;
            rdata1_p1 <= forward(idRs1, idReadData1, wbRegisterWrite, wbRd, wbWriteData);
            rdata2_p1 <= forward(idRs2, idReadData2, wbRegisterWrite, wbRd, wbWriteData);
            rs1_p1    <= idRs1;
            rs2_p1    <= idRs2;
            rd_p1     <= idRd;
            imm_p1    <= idImmediate;
            ctrl_p1   <= idControl;
        end
    end

    assign exValid     = vld_p1;
    assign exPc        = pc_p1;
    assign exReadData1 = rdata1_p1;
    assign exReadData2 = rdata2_p1;
    assign exRs1       = rs1_p1;
    assign exRs2       = rs2_p1;
    assign exRd        = rd_p1;
    assign exImmediate = imm_p1;
    assign exControl   = ctrl_p1;

endmodule
